sec_encoder_stream: RTL and testbench

SEC_ENCODER_STREAM -- requirements
Module: sec_encoder_stream

---
 rtl/sec_encoder_stream.sv | 132 +++++++++++++
 tb/tb_sec_encoder_stream.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sec_encoder_stream.sv
// Streaming 32-bit SEC encoder: two-stage valid/ready pipeline with
// 8 check bits, single-bit error injection and an output word counter.
module sec_encoder_stream #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [7:0]       out_chk,
   input  logic             inj_arm,
   input  logic [5:0]       inj_pos,
   output logic             inj_armed,
   output logic [CNT_W-1:0] word_cnt
);

   logic             s1_valid_q;
   logic [31:0]      s1_data_q;
   logic [7:0]       s1_np_q;
   logic [7:0]       s1_col_q;
   logic             s1_mark_q;
   logic [5:0]       s1_pos_q;

   logic             out_valid_q;
   logic [31:0]      out_data_q;
   logic [7:0]       out_chk_q;

   logic             armed_q;
   logic [5:0]       arm_pos_q;
   logic [CNT_W-1:0] cnt_q;

   logic             s2_adv;
   logic             s1_adv;
   logic             in_fire;
   logic             out_fire;
   logic [7:0]       np_d;
   logic [7:0]       col_d;
   logic [7:0]       chk_d;
   logic [39:0]      flip_d;
   logic [39:0]      cw_d;

   assign s2_adv   = !out_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;
   assign in_fire  = in_valid && s1_adv;
   assign out_fire = out_valid_q && out_ready;

   // Nibble parities and per-half column parities (bit b of each nibble).
   always_comb begin
      np_d  = '0;
      col_d = '0;
      for (int j = 0; j < 8; j++) begin
         np_d[j] = ^in_data[4*j +: 4];
      end
      for (int b = 0; b < 4; b++) begin
         col_d[b]   = in_data[b]    ^ in_data[b+4]
                    ^ in_data[b+8]  ^ in_data[b+12];
         col_d[b+4] = in_data[b+16] ^ in_data[b+20]
                    ^ in_data[b+24] ^ in_data[b+28];
      end
   end

   assign chk_d[0] = s1_np_q[4] ^ s1_np_q[5] ^ s1_col_q[0];
   assign chk_d[1] = s1_np_q[6] ^ s1_np_q[7] ^ s1_col_q[1];
   assign chk_d[2] = s1_np_q[4] ^ s1_np_q[6] ^ s1_col_q[2];
   assign chk_d[3] = s1_np_q[5] ^ s1_np_q[7] ^ s1_col_q[3];
   assign chk_d[4] = s1_np_q[0] ^ s1_np_q[1] ^ s1_col_q[4];
   assign chk_d[5] = s1_np_q[2] ^ s1_np_q[3] ^ s1_col_q[5];
   assign chk_d[6] = s1_np_q[0] ^ s1_np_q[2] ^ s1_col_q[6];
   assign chk_d[7] = s1_np_q[1] ^ s1_np_q[3] ^ s1_col_q[7];

   // Positions 40-63 fall off the codeword and leave it untouched.
   assign flip_d = (s1_mark_q && (s1_pos_q < 6'd40))
                 ? (40'd1 << s1_pos_q) : 40'd0;
   assign cw_d   = {chk_d, s1_data_q} ^ flip_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_np_q     <= '0;
         s1_col_q    <= '0;
         s1_mark_q   <= 1'b0;
         s1_pos_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chk_q   <= '0;
         armed_q     <= 1'b0;
         arm_pos_q   <= '0;
         cnt_q       <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_fire) begin
               s1_data_q <= in_data;
               s1_np_q   <= np_d;
               s1_col_q  <= col_d;
               s1_mark_q <= armed_q;
               s1_pos_q  <= arm_pos_q;
            end
         end
         if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               out_data_q <= cw_d[31:0];
               out_chk_q  <= cw_d[39:32];
            end
         end
         // A fresh arm wins over the clear caused by an acceptance.
         if (inj_arm) begin
            armed_q   <= 1'b1;
            arm_pos_q <= inj_pos;
         end else if (in_fire) begin
            armed_q <= 1'b0;
         end
         if (out_fire) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chk   = out_chk_q;
   assign inj_armed = armed_q;
   assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_sec_encoder_stream.sv
// Scoreboard bench for sec_encoder_stream: mask-based reference encoder,
// syndrome decoder, directed vectors and randomized valid/ready traffic.
`timescale 1ns/1ps
module tb_sec_encoder_stream;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   out_data;
   logic [7:0]    out_chk;
   logic          inj_arm = 1'b0;
   logic [5:0]    inj_pos = '0;
   logic          inj_armed;
   logic [CW-1:0] word_cnt;

   always #5 clk = ~clk;

   sec_encoder_stream #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_chk(out_chk),
      .inj_arm(inj_arm), .inj_pos(inj_pos), .inj_armed(inj_armed),
      .word_cnt(word_cnt)
   );

   // Check bit k = XOR of the data bits listed for it.
   localparam logic [31:0] MASK [8] = '{
      32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
      32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
   };

   typedef struct {
      logic [31:0] data;
      logic [7:0]  chk;
      logic [31:0] orig;
      int          cyc;
   } item_t;

   item_t       sbq[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   bit          lat_chk = 0;
   bit          rnd_done = 0;
   logic        m_armed = 1'b0;
   logic [5:0]  m_pos = '0;
   int          m_cnt = 0;
   logic        hold = 1'b0;
   logic [39:0] held = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] enc(input logic [31:0] d);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[k] = ^(d & MASK[k]);
      return r;
   endfunction

   function automatic logic [31:0] dec(input logic [31:0] d,
                                       input logic [7:0] c);
      logic [7:0]  s;
      logic [7:0]  col;
      logic [31:0] m;
      logic [31:0] r;
      r = d;
      s = enc(d) ^ c;
      for (int i = 0; i < 32; i++) begin
         for (int k = 0; k < 8; k++) begin
            m = MASK[k];
            col[k] = m[i];
         end
         if (s == col) r[i] = ~r[i];
      end
      return r;
   endfunction

   always @(negedge clk) begin : in_mon
      item_t       it;
      logic        acc;
      logic [39:0] cw;
      if (!rst_n) begin
         m_armed = 1'b0;
      end else begin
         check("inj_armed", inj_armed, m_armed);
         acc = in_valid && in_ready;
         if (acc) begin
            cw = {enc(in_data), in_data};
            if (m_armed && m_pos < 6'd40) cw[m_pos] = ~cw[m_pos];
            it.data = cw[31:0];
            it.chk  = cw[39:32];
            it.orig = in_data;
            it.cyc  = cyc;
            sbq.push_back(it);
         end
         if (inj_arm) begin
            m_armed = 1'b1;
            m_pos   = inj_pos;
         end else if (acc) begin
            m_armed = 1'b0;
         end
      end
   end

   always @(negedge clk) begin : out_mon
      item_t it;
      if (!rst_n) begin
         sbq.delete();
         m_cnt = 0;
         hold  = 1'b0;
      end else begin
         check("word_cnt", word_cnt, m_cnt);
         if (hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_word", {out_chk, out_data}, held);
         end
         hold = out_valid && !out_ready;
         held = {out_chk, out_data};
         if (out_valid && out_ready) begin
            check("word_expected", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
               it = sbq.pop_front();
               check("out_data", out_data, it.data);
               check("out_chk", out_chk, it.chk);
               check("decode", dec(out_data, out_chk), it.orig);
               if (lat_chk) check("latency", cyc - it.cyc, 2);
            end
            m_cnt = (m_cnt + 1) % (1 << CW);
         end
      end
   end

   task automatic send(input logic [31:0] d);
      int n;
      bit acc;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      in_valid = 1'b0;
      check("send_accept", acc, 1);
   endtask

   task automatic send_expect(input logic [31:0] d,
                              input logic [7:0] exp_chk,
                              input logic [31:0] exp_data);
      send(d);
      check("armed_clear", inj_armed, inj_arm);
      @(posedge clk);
      #1;
      check("dir_valid", out_valid, 1);
      check("dir_chk", out_chk, exp_chk);
      check("dir_data", out_data, exp_data);
   endtask

   task automatic arm(input logic [5:0] p);
      inj_arm = 1'b1;
      inj_pos = p;
      @(posedge clk);
      #1;
      inj_arm = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reset_checks();
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_inj_armed", inj_armed, 0);
      check("rst_word_cnt", word_cnt, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_chk", out_chk, 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int r;
      out_ready = 1'b1;
      idle(3);
      rst_n = 1'b1;
      reset_checks();
      lat_chk = 1;

      for (int i = 0; i < 8; i++) send($urandom);
      idle(3);
      check("stream_cnt", word_cnt, 8);

      send_expect(32'h00000000, 8'h00, 32'h00000000);
      send_expect(32'h00000001, 8'h51, 32'h00000001);
      send_expect(32'h00010000, 8'h15, 32'h00010000);
      send_expect(32'hFFFFFFFF, 8'h00, 32'hFFFFFFFF);

      arm(6'd35);
      check("armed_set", inj_armed, 1);
      send_expect(32'h00000001, 8'h59, 32'h00000001);
      send_expect(32'h00000001, 8'h51, 32'h00000001);
      arm(6'd45);
      send_expect(32'h00000001, 8'h51, 32'h00000001);
      arm(6'd3);
      arm(6'd33);
      send_expect(32'h00000000, 8'h02, 32'h00000000);

      inj_arm = 1'b1;
      inj_pos = 6'd0;
      send(32'h0);
      inj_arm = 1'b0;
      send_expect(32'h00000000, 8'h00, 32'h00000001);

      arm(6'd5);
      inj_arm = 1'b1;
      inj_pos = 6'd6;
      send(32'h0);
      inj_arm = 1'b0;
      check("rearm_kept", inj_armed, 1);
      send_expect(32'h00000000, 8'h00, 32'h00000040);
      idle(3);

      lat_chk = 0;
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) send(32'hA0000000 + i);
         end
         begin
            idle(3);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            idle(2);
            out_ready = 1'b1;
         end
      join
      idle(4);
      check("bp_drained", sbq.size(), 0);

      fork
         begin
            for (int i = 0; i < 400; i++) begin
               r = $urandom_range(0, 9);
               if (r < 2) begin
                  inj_arm = (r == 0);
                  inj_pos = 6'($urandom_range(0, 63));
                  idle(1);
                  inj_arm = 1'b0;
               end else begin
                  if (r == 2) begin
                     inj_arm = 1'b1;
                     inj_pos = 6'($urandom_range(0, 63));
                  end
                  send($urandom);
                  inj_arm = 1'b0;
               end
            end
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               out_ready = ($urandom_range(0, 2) != 0);
               idle(1);
            end
         end
      join
      out_ready = 1'b1;
      for (int i = 0; i < 100 && sbq.size() != 0; i++) idle(1);
      check("rnd_drained", sbq.size(), 0);

      send(32'h1);
      send(32'h2);
      arm(6'd9);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'h5;
      idle(1);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      reset_checks();
      idle(3);
      check("rst_no_output", out_valid, 0);
      send_expect(32'h00000004, enc(32'h4), 32'h00000004);
      idle(2);
      check("post_rst_cnt", word_cnt, 1);
      check("final_empty", sbq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
